// File: rtl/div_arbiter_pkg.sv
// Shared types and round-robin search for the divide arbiter.
// Imported by the arbiter top and its sequential divider.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB,
        START,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_OP,
        D_DONE
    } div_state_t;

    localparam int RR_IDW = 4;
    localparam int RR_MAX = 1 << RR_IDW;

    // First set bit at or after 'first', wrapping within n entries.
    function automatic int rr_pick(
        input logic [RR_MAX-1:0] req,
        input int                n,
        input int                first
    );
        int   idx;
        logic found;
        rr_pick = first;
        found   = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = first + k;
            if (idx >= n) idx = idx - n;
            if (!found && k < n && req[idx[RR_IDW-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/div_arbiter_div.sv
// Restoring sequential divider: one quotient bit per clock.
// The first bit is produced on the start edge, done_tick follows W cycles later.
module div
    import div_arbiter_pkg::*;
#(
    parameter int W    = 8,
    parameter int CBIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dvsr,
    input  logic [W-1:0] dvnd,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd
);

    div_state_t      st, st_n;
    logic [W-1:0]    rh, rl, d;
    logic [W-1:0]    src_rh, src_rl, src_d;
    logic [W-1:0]    rh_n, rl_n;
    logic [W:0]      t;
    logic            ge;
    logic            load, step;
    logic [CBIT-1:0] n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= D_IDLE;
        else       st <= st_n;
    end

    always_comb begin
        st_n = st;
        load = 1'b0;
        step = 1'b0;
        case (st)
            D_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    st_n = D_OP;
                end
            end
            D_OP: begin
                step = 1'b1;
                if (n == CBIT'(1)) st_n = D_DONE;
            end
            D_DONE:  st_n = D_IDLE;
            default: st_n = D_IDLE;
        endcase
    end

    // Shared step: on load it works straight from the input operands.
    always_comb begin
        src_rh = load ? '0   : rh;
        src_rl = load ? dvnd : rl;
        src_d  = load ? dvsr : d;
        t      = {src_rh, src_rl[W-1]};
        ge     = (t >= {1'b0, src_d});
        rh_n   = ge ? (t[W-1:0] - src_d) : t[W-1:0];
        rl_n   = {src_rl[W-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rh <= '0;
            rl <= '0;
            d  <= '0;
            n  <= '0;
        end else if (load) begin
            rh <= rh_n;
            rl <= rl_n;
            d  <= dvsr;
            n  <= CBIT'(W - 1);
        end else if (step) begin
            rh <= rh_n;
            rl <= rl_n;
            n  <= n - 1'b1;
        end
    end

    assign done_tick = (st == D_DONE);
    assign quo       = rl;
    assign rmd       = rh;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N requesters.
// Zero divisors bypass the divider and report all-ones quotient with dbz set.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dvnd_in,
    input  logic [N*W-1:0] dvsr_in,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   quo,
    output logic [W-1:0]   rmd,
    output logic [IDW-1:0] owner,
    output logic           dbz,
    output logic           busy
);

    arb_state_t        state, state_n;
    logic [IDW-1:0]    ptr, idx, win;
    logic [W-1:0]      dvnd_r, dvsr_r;
    logic [W-1:0]      dvnd_a [N];
    logic [W-1:0]      dvsr_a [N];
    logic [RR_MAX-1:0] req_pad;
    logic              grant, zero, finish;
    logic              div_start, div_done, div_rst;
    logic [W-1:0]      div_quo, div_rmd;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign dvnd_a[i] = dvnd_in[i*W +: W];
        assign dvsr_a[i] = dvsr_in[i*W +: W];
    end

    assign req_pad = RR_MAX'(req);
    assign win     = IDW'(rr_pick(req_pad, N, int'(ptr)));
    assign busy    = (state != ARB);
    assign div_rst = ~reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        zero      = 1'b0;
        finish    = 1'b0;
        div_start = 1'b0;
        case (state)
            ARB: begin
                if (|req) begin
                    grant   = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (dvsr_r == '0) begin
                    zero    = 1'b1;
                    state_n = RESP;
                end else begin
                    div_start = 1'b1;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (div_done) begin
                    finish  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = ARB;
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            idx    <= '0;
            dvnd_r <= '0;
            dvsr_r <= '0;
            gnt    <= '0;
            done   <= '0;
            quo    <= '0;
            rmd    <= '0;
            owner  <= '0;
            dbz    <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (grant) begin
                idx    <= win;
                dvnd_r <= dvnd_a[win];
                dvsr_r <= dvsr_a[win];
                ptr    <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
                gnt    <= N'(1) << win;
            end
            if (zero) begin
                quo   <= '1;
                rmd   <= dvnd_r;
                dbz   <= 1'b1;
                owner <= idx;
            end
            if (finish) begin
                quo   <= div_quo;
                rmd   <= div_rmd;
                dbz   <= 1'b0;
                owner <= idx;
            end
            // Results are already registered when RESP is entered.
            if (state == RESP) done <= N'(1) << owner;
        end
    end

    div #(
        .W    (W),
        .CBIT (W)
    ) u_div (
        .clk       (clk),
        .reset     (div_rst),
        .start     (div_start),
        .dvsr      (dvsr_r),
        .dvnd      (dvnd_r),
        .done_tick (div_done),
        .quo       (div_quo),
        .rmd       (div_rmd)
    );

endmodule
